preemption_controller: RTL

Parametrised context-switch controller for the multiprogrammed processor. It sits beside the PC-update logic and counts retired user instructions against a programmable quantum. On quantum expiry or an I/O trap it saves the running process's resume PC into a per-process table and forces the PC to the scheduler or the I/O handler. It restores a selected process's PC when the scheduler issues a resume.

---
 rtl/preemption_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/preemption_controller.sv
// Context-switch controller: counts retired user instructions against a quantum and
// swaps the PC between user processes, the scheduler and the I/O handler.
module preemption_controller #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_PROC    = 4,
    parameter int unsigned PID_W       = 2,
    parameter int unsigned Q_W         = 8,
    parameter int unsigned QUANTUM_DEF = 16,
    parameter int unsigned SCHED_ADDR  = 0,
    parameter int unsigned IO_ADDR     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_done,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc_ret,
    input  logic              io_trap,
    input  logic              sel_proc,
    input  logic [PID_W-1:0]  proc_id,
    input  logic              resume,
    input  logic              quantum_load,
    input  logic [Q_W-1:0]    quantum_val,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              modo_os,
    output logic [PID_W-1:0]  processo_atual,
    output logic [1:0]        motivo,
    output logic [Q_W-1:0]    quantum_left
);
    typedef enum logic {OS, USER} state_t;

    state_t            state;
    logic [Q_W-1:0]    quantum_reg;
    logic [ADDR_W-1:0] pc_table [NUM_PROC];

    logic              sel_valid;
    logic [PID_W-1:0]  resume_id;
    logic [Q_W-1:0]    quantum_new;
    logic              expiry;

    always_comb begin
        sel_valid   = sel_proc && (32'(proc_id) < NUM_PROC);
        resume_id   = sel_valid ? proc_id : processo_atual;
        quantum_new = (quantum_val == '0) ? Q_W'(1) : quantum_val;
        expiry      = instr_done && (quantum_left == Q_W'(1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= OS;
            modo_os        <= 1'b1;
            processo_atual <= '0;
            pc_load        <= 1'b0;
            pc_next        <= '0;
            motivo         <= 2'b00;
            quantum_reg    <= Q_W'(QUANTUM_DEF);
            quantum_left   <= Q_W'(QUANTUM_DEF);
            for (int unsigned i = 0; i < NUM_PROC; i++) begin
                pc_table[i] <= '0;
            end
        end else begin
            pc_load <= 1'b0;
            // A quantum reload only reaches quantum_left through the next resume
            if (quantum_load) begin
                quantum_reg <= quantum_new;
            end
            case (state)
                USER: begin
                    if (!halt) begin
                        // io_trap takes priority over a coincident expiry
                        if (io_trap || expiry) begin
                            pc_table[processo_atual] <= pc_ret;
                            pc_next      <= io_trap ? ADDR_W'(IO_ADDR) : ADDR_W'(SCHED_ADDR);
                            motivo       <= io_trap ? 2'b10 : 2'b01;
                            pc_load      <= 1'b1;
                            quantum_left <= '0;
                            state        <= OS;
                            modo_os      <= 1'b1;
                        end else if (instr_done && quantum_left != '0) begin
                            quantum_left <= quantum_left - Q_W'(1);
                        end
                    end
                end
                OS: begin
                    if (sel_valid) begin
                        processo_atual <= proc_id;
                    end
                    if (resume) begin
                        pc_next      <= pc_table[resume_id];
                        pc_load      <= 1'b1;
                        quantum_left <= quantum_reg;
                        motivo       <= 2'b00;
                        state        <= USER;
                        modo_os      <= 1'b0;
                    end
                end
                default: state <= OS;
            endcase
        end
    end
endmodule
